// File: rtl/mycpu_pkg.sv
// Shared CPU-level types and constants: the memory-port arbiter's state
// encoding, its default sizing, and the requester index assignments.
package mycpu_pkg;

  typedef enum logic [0:0] {
    ARB_IDLE = 1'b0,
    ARB_OWN  = 1'b1
  } arb_state_t;

  localparam int ARB_NREQ      = 2;
  localparam int ARB_MAX_BEATS = 4;

  // Requester slots on the shared memory port.
  localparam int ARB_REQ_FETCH = 0;
  localparam int ARB_REQ_LSU   = 1;

endpackage

// File: rtl/mem_port_arbiter_rr_pick.sv
// Combinational round-robin picker: returns the first requester at or after
// ptr_i (with wrap-around) that is requesting and is not masked by excl_i.
module rr_pick #(
  parameter int NREQ = 2,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IW-1:0]   ptr_i,
  input  logic [NREQ-1:0] excl_i,
  output logic            valid_o,
  output logic [IW-1:0]   index_o
);

  int cand;

  // Scan from ptr_i upward; the first eligible candidate wins.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    valid_o = 1'b0;
    index_o = '0;
    cand    = 0;
    for (int i = 0; i < NREQ; i++) begin
      cand = (int'(ptr_i) + i) % NREQ;
      if (!valid_o && req_i[cand] && !excl_i[cand]) begin
        valid_o = 1'b1;
        index_o = IW'(cand);
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin owner arbitration for the CPU's single 16-bit memory port.
// A grant is held for a burst of at most MAX_BEATS accepted beats; sel_out
// feeds the select of the 2:1 data mux in front of the port and keeps the
// last owner while idle so the mux does not toggle.
module mem_port_arbiter
  import mycpu_pkg::*;
#(
  parameter int NREQ      = ARB_NREQ,
  parameter int MAX_BEATS = ARB_MAX_BEATS
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_in,
  input  logic [NREQ-1:0]         last_in,
  input  logic                    port_ready_in,
  output logic [NREQ-1:0]         gnt_out,
  output logic [$clog2(NREQ)-1:0] sel_out,
  output logic                    busy_out,
  output logic                    beat_out
);

  localparam int SW = $clog2(NREQ);
  localparam int CW = $clog2(MAX_BEATS + 1);

  arb_state_t      state_q;
  logic [NREQ-1:0] gnt_q;
  logic [SW-1:0]   sel_q;
  logic            busy_q;
  logic [SW-1:0]   rr_ptr_q;
  logic [CW-1:0]   count_q;

  logic            own;
  logic            beat;
  logic [CW-1:0]   count_d;
  logic            cap_hit;
  logic            forced;
  logic            release_w;
  logic [SW-1:0]   rr_ptr_d;
  logic [SW-1:0]   pick_ptr;
  logic [NREQ-1:0] pick_excl;
  logic            pick_valid;
  logic [SW-1:0]   pick_idx;
  logic [NREQ-1:0] pick_onehot;

  // Beat accounting, release detection and the picker's search setup.
  always_comb begin
    own      = (state_q == ARB_OWN);
    beat     = own && req_in[sel_q] && port_ready_in;
    count_d  = count_q + CW'(1);
    cap_hit  = (count_d == CW'(MAX_BEATS));
    // Burst cap reached while the owner still wants more: it may re-compete,
    // sitting last in priority because the search starts just after it.
    forced   = beat && cap_hit && !last_in[sel_q];
    release_w = own && ((beat && (last_in[sel_q] || cap_hit)) || !req_in[sel_q]);
    rr_ptr_d = (sel_q == SW'(NREQ - 1)) ? '0 : sel_q + SW'(1);
    pick_ptr = own ? rr_ptr_d : rr_ptr_q;
    pick_excl = '0;
    if (own && !forced) begin
      pick_excl[sel_q] = 1'b1;
    end
    pick_onehot = NREQ'(1) << pick_idx;
  end

  rr_pick #(
    .NREQ (NREQ),
    .IW   (SW)
  ) u_rr_pick (
    .req_i   (req_in),
    .ptr_i   (pick_ptr),
    .excl_i  (pick_excl),
    .valid_o (pick_valid),
    .index_o (pick_idx)
  );

  // Owner FSM with registered grant, select and busy outputs.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (rst) begin
      state_q  <= ARB_IDLE;
      gnt_q    <= '0;
      sel_q    <= '0;
      busy_q   <= 1'b0;
      rr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      case (state_q)
        ARB_IDLE: begin
          if (pick_valid) begin
            state_q <= ARB_OWN;
            gnt_q   <= pick_onehot;
            sel_q   <= pick_idx;
            busy_q  <= 1'b1;
            count_q <= '0;
          end
        end
        ARB_OWN: begin
          if (release_w) begin
            rr_ptr_q <= rr_ptr_d;
            count_q  <= '0;
            if (pick_valid) begin
              gnt_q <= pick_onehot;
              sel_q <= pick_idx;
            end else begin
              state_q <= ARB_IDLE;
              gnt_q   <= '0;
              busy_q  <= 1'b0;
            end
          end else if (beat) begin
            count_q <= count_d;
          end
        end
        default: state_q <= ARB_IDLE;
      endcase
    end
  end

  assign gnt_out  = gnt_q;
  assign sel_out  = sel_q;
  assign busy_out = busy_q;
  assign beat_out = beat;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a table of per-cycle inputs with
// hand-computed outputs, followed by a hand-written stall/burst-cap sequence.
module tb_mem_port_arbiter;

  logic       clk;
  logic       rst;
  logic [1:0] req_in;
  logic [1:0] last_in;
  logic       port_ready_in;
  logic [1:0] gnt_out;
  logic       sel_out;
  logic       busy_out;
  logic       beat_out;

  int n_vec  = 0;
  int n_miss = 0;

  typedef struct {
    logic       rst;
    logic [1:0] req;
    logic [1:0] last;
    logic       rdy;
    logic [1:0] gnt;
    logic       sel;
    logic       busy;
    logic       beat;
  } vec_t;

  vec_t vq[$];

  mem_port_arbiter #(
    .NREQ      (2),
    .MAX_BEATS (4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .req_in        (req_in),
    .last_in       (last_in),
    .port_ready_in (port_ready_in),
    .gnt_out       (gnt_out),
    .sel_out       (sel_out),
    .busy_out      (busy_out),
    .beat_out      (beat_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0b, expected %0b", name, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic [1:0] rq, input logic [1:0] l, input logic rd,
                     input logic [1:0] g, input logic s, input logic b, input logic bt);
    vec_t v;
    v.rst = r; v.req = rq; v.last = l; v.rdy = rd;
    v.gnt = g; v.sel = s; v.busy = b; v.beat = bt;
    vq.push_back(v);
  endtask

  // Drive one cycle's inputs just after the rising edge; outputs are then
  // sampled a few ns later, well before the next edge.
  task automatic cyc(input logic r, input logic [1:0] rq, input logic [1:0] l, input logic rd);
    @(posedge clk);
    #1;
    rst = r; req_in = rq; last_in = l; port_ready_in = rd;
    #3;
  endtask

  initial begin
    bit seen;
    rst = 1'b1; req_in = 2'b00; last_in = 2'b00; port_ready_in = 1'b0;

    // rst req last rdy | gnt sel busy beat (outputs seen during that cycle)
    add(1, 2'b11, 2'b00, 0, 2'b00, 0, 0, 0);  // reset held with both requesting
    add(1, 2'b11, 2'b00, 0, 2'b00, 0, 0, 0);
    add(0, 2'b11, 2'b00, 0, 2'b00, 0, 0, 0);  // rst drops: req0 wins from ptr 0
    add(0, 2'b00, 2'b00, 0, 2'b01, 0, 1, 0);  // granted; owner abandons
    add(0, 2'b00, 2'b00, 0, 2'b00, 0, 0, 0);
    add(0, 2'b10, 2'b00, 1, 2'b00, 0, 0, 0);  // single requester 1
    add(0, 2'b10, 2'b00, 1, 2'b10, 1, 1, 1);  // beat 1
    add(0, 2'b10, 2'b00, 1, 2'b10, 1, 1, 1);  // beat 2
    add(0, 2'b10, 2'b10, 1, 2'b10, 1, 1, 1);  // beat 3 with last
    add(0, 2'b00, 2'b00, 1, 2'b00, 1, 0, 0);  // idle, sel holds 1
    add(0, 2'b00, 2'b00, 0, 2'b00, 1, 0, 0);
    add(0, 2'b11, 2'b00, 1, 2'b00, 1, 0, 0);  // contention, ptr 0
    add(0, 2'b11, 2'b00, 1, 2'b01, 0, 1, 1);
    add(0, 2'b11, 2'b01, 1, 2'b01, 0, 1, 1);
    add(0, 2'b11, 2'b00, 1, 2'b10, 1, 1, 1);  // back-to-back to req1
    add(0, 2'b11, 2'b10, 1, 2'b10, 1, 1, 1);
    add(0, 2'b11, 2'b00, 1, 2'b01, 0, 1, 1);
    add(0, 2'b11, 2'b01, 1, 2'b01, 0, 1, 1);
    add(0, 2'b11, 2'b00, 1, 2'b10, 1, 1, 1);
    add(0, 2'b10, 2'b10, 1, 2'b10, 1, 1, 1);  // req1 ends, nobody else
    add(0, 2'b00, 2'b00, 0, 2'b00, 1, 0, 0);
    add(0, 2'b01, 2'b00, 1, 2'b00, 1, 0, 0);  // burst cap, req0 alone
    add(0, 2'b01, 2'b00, 1, 2'b01, 0, 1, 1);  // beat 1
    add(0, 2'b01, 2'b00, 1, 2'b01, 0, 1, 1);  // beat 2
    add(0, 2'b01, 2'b00, 1, 2'b01, 0, 1, 1);  // beat 3
    add(0, 2'b01, 2'b00, 1, 2'b01, 0, 1, 1);  // beat 4: cap, re-granted
    add(0, 2'b01, 2'b00, 1, 2'b01, 0, 1, 1);  // new burst beat 1
    add(0, 2'b01, 2'b00, 1, 2'b01, 0, 1, 1);  // beat 2
    add(0, 2'b01, 2'b00, 1, 2'b01, 0, 1, 1);  // beat 3
    add(0, 2'b11, 2'b00, 1, 2'b01, 0, 1, 1);  // beat 4 with req1 pending
    add(0, 2'b11, 2'b10, 0, 2'b10, 1, 1, 0);  // req1 owns; stall with last
    add(0, 2'b11, 2'b10, 0, 2'b10, 1, 1, 0);
    add(0, 2'b11, 2'b10, 0, 2'b10, 1, 1, 0);
    add(0, 2'b11, 2'b10, 0, 2'b10, 1, 1, 0);
    add(0, 2'b11, 2'b10, 0, 2'b10, 1, 1, 0);
    add(0, 2'b11, 2'b10, 1, 2'b10, 1, 1, 1);  // single beat releases
    add(0, 2'b01, 2'b01, 1, 2'b01, 0, 1, 1);  // req0 one-beat burst
    add(0, 2'b10, 2'b00, 0, 2'b00, 0, 0, 0);  // ptr now 1
    add(0, 2'b11, 2'b00, 0, 2'b10, 1, 1, 0);  // req1 owns, ptr 1
    add(1, 2'b11, 2'b00, 0, 2'b10, 1, 1, 0);  // reset during OWN
    add(0, 2'b11, 2'b00, 0, 2'b00, 0, 0, 0);  // cleared; ptr back to 0
    add(0, 2'b01, 2'b00, 1, 2'b01, 0, 1, 1);  // req0 wins, beat
    add(0, 2'b00, 2'b00, 1, 2'b01, 0, 1, 0);  // abandon mid-burst
    add(0, 2'b00, 2'b00, 0, 2'b00, 0, 0, 0);

    @(posedge clk);
    foreach (vq[i]) begin
      cyc(vq[i].rst, vq[i].req, vq[i].last, vq[i].rdy);
      check($sformatf("vec%0d gnt/sel/busy/beat", i),
            {27'd0, gnt_out, sel_out, busy_out, beat_out},
            {27'd0, vq[i].gnt, vq[i].sel, vq[i].busy, vq[i].beat});
    end

    // Stall cycles must not advance the beat count: req1 owns, stalls five
    // cycles with last held, then needs four full beats to hit the cap.
    cyc(0, 2'b10, 2'b00, 0);
    check("seq idle before grant busy", {31'd0, busy_out}, 32'd0);
    cyc(0, 2'b10, 2'b10, 0);
    check("seq grant latency", {30'd0, gnt_out}, 32'b10);
    for (int k = 0; k < 4; k++) begin
      cyc(0, 2'b10, 2'b10, 0);
      check($sformatf("seq stall%0d gnt/beat", k), {29'd0, gnt_out, beat_out}, 32'b100);
    end
    for (int k = 1; k <= 4; k++) begin
      cyc(0, 2'b11, 2'b00, 1);
      check($sformatf("seq cap beat%0d gnt/beat", k), {29'd0, gnt_out, beat_out}, 32'b101);
    end
    cyc(0, 2'b00, 2'b00, 0);
    check("seq handover after cap gnt/sel", {29'd0, gnt_out, sel_out}, 32'b010);

    // Bounded wait for the abandoned grant to fall back to idle.
    seen = 1'b0;
    for (int k = 0; k < 4 && !seen; k++) begin
      cyc(0, 2'b00, 2'b00, 0);
      if (!busy_out) seen = 1'b1;
    end
    check("seq return to idle", {31'd0, seen}, 32'd1);
    check("seq idle gnt/sel", {29'd0, gnt_out, sel_out}, 32'b000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
